// File: rtl/ee201_numlock_pkg.sv
// Shared definitions for the number-lock pushbutton conditioner:
// debounce FSM state encoding and debounce-length defaults.
package ee201_numlock_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        DEB_PRESS = 2'b01,
        HELD      = 2'b11,
        DEB_REL   = 2'b10
    } deb_state_e;

    // 10 ms at 50 MHz for hardware; a short count keeps simulation quick.
    localparam int unsigned DEBOUNCE_CYCLES_SYN = 500000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

    function automatic logic state_level(input deb_state_e s);
        return (s == HELD) || (s == DEB_REL);
    endfunction

    function automatic logic state_busy(input deb_state_e s);
        return (s == DEB_PRESS) || (s == DEB_REL);
    endfunction

endpackage

// File: rtl/ee201_numlock_btn_cond_if.sv
// One conditioned pushbutton channel: raw input plus debounced level,
// press pulse and qualification-busy flag.
interface ee201_numlock_btn_cond_if;

    logic raw;
    logic level;
    logic sp;
    logic busy;

    modport master (
        output raw,
        input  level,
        input  sp,
        input  busy
    );

    modport slave (
        input  raw,
        output level,
        output sp,
        output busy
    );

endinterface

// File: rtl/ee201_debouncer.sv
// Single pushbutton channel: 2-flop synchronizer feeding a 4-state debounce
// FSM whose level, press pulse and busy flag are all registered.
module ee201_debouncer
    import ee201_numlock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ee201_numlock_btn_cond_if.slave     btn
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q;
    logic             s2_q;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             sp_q;
    logic             sp_d;
    logic             busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            sp_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s1_q    <= btn.raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= state_level(state_d);
            sp_q    <= sp_d;
            busy_q  <= state_busy(state_d);
        end
    end

    // Any opposite-sense sample during qualification aborts and clears the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sp_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = DEB_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    sp_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = DEB_REL;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            DEB_REL: begin
                if (s2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn.level = level_q;
    assign btn.sp    = sp_q;
    assign btn.busy  = busy_q;

endmodule

// File: rtl/ee201_numlock_btn_cond.sv
// Two-channel (U, Z) pushbutton conditioner in front of the number-lock FSM;
// wiring only, each channel is an independent ee201_debouncer.
module ee201_numlock_btn_cond
    import ee201_numlock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic U_raw,
    input  logic Z_raw,
    output logic U,
    output logic Z,
    output logic U_sp,
    output logic Z_sp,
    output logic U_busy,
    output logic Z_busy
);

    ee201_numlock_btn_cond_if u_btn ();
    ee201_numlock_btn_cond_if z_btn ();

    assign u_btn.raw = U_raw;
    assign z_btn.raw = Z_raw;

    ee201_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_u (
        .clk   (clk),
        .rst_n (reset),
        .btn   (u_btn)
    );

    ee201_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_z (
        .clk   (clk),
        .rst_n (reset),
        .btn   (z_btn)
    );

    assign U      = u_btn.level;
    assign U_sp   = u_btn.sp;
    assign U_busy = u_btn.busy;
    assign Z      = z_btn.level;
    assign Z_sp   = z_btn.sp;
    assign Z_busy = z_btn.busy;

endmodule

// File: tb/tb_ee201_numlock_btn_cond.sv
// Directed bench for the two-channel pushbutton conditioner
// (DEBOUNCE_CYCLES=4, CNT_W=3, 200 ns clock).
module tb_ee201_numlock_btn_cond;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   sp_cnt;

    ee201_numlock_btn_cond_if u_ch ();
    ee201_numlock_btn_cond_if z_ch ();

    ee201_numlock_btn_cond #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .U_raw  (u_ch.raw),
        .Z_raw  (z_ch.raw),
        .U      (u_ch.level),
        .Z      (z_ch.level),
        .U_sp   (u_ch.sp),
        .Z_sp   (z_ch.sp),
        .U_busy (u_ch.busy),
        .Z_busy (z_ch.busy)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " U"},      u_ch.level, 1'b0);
        check({tag, " Z"},      z_ch.level, 1'b0);
        check({tag, " U_sp"},   u_ch.sp,    1'b0);
        check({tag, " Z_sp"},   z_ch.sp,    1'b0);
        check({tag, " U_busy"}, u_ch.busy,  1'b0);
        check({tag, " Z_busy"}, z_ch.busy,  1'b0);
    endtask

    // Raw U already at 1: expect rise exactly 5 edges after first sample.
    task automatic expect_u_rise(input string tag);
        for (int i = 1; i <= 5; i++) begin
            step();
            check({tag, " U low"},  u_ch.level, 1'b0);
            check({tag, " sp low"}, u_ch.sp,    1'b0);
            if (i >= 3) check({tag, " busy"}, u_ch.busy, 1'b1);
        end
        step();
        check({tag, " U rise"},   u_ch.level, 1'b1);
        check({tag, " sp pulse"}, u_ch.sp,    1'b1);
        check({tag, " busy off"}, u_ch.busy,  1'b0);
        step();
        check({tag, " sp 1clk"},  u_ch.sp,    1'b0);
        check({tag, " U held"},   u_ch.level, 1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        u_ch.raw    = 1'b0;
        z_ch.raw    = 1'b0;

        // 1. reset state, then release with U_raw low
        step();
        step();
        check_all_zero("reset");
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("post-reset U",    u_ch.level, 1'b0);
            check("post-reset U_sp", u_ch.sp,    1'b0);
        end

        // 2. clean press, hold 20 cycles, release
        u_ch.raw = 1'b1;
        expect_u_rise("clean");
        sp_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            step();
            if (u_ch.sp) sp_cnt++;
            check("hold U", u_ch.level, 1'b1);
        end
        check("hold single sp", (sp_cnt == 0), 1'b1);
        u_ch.raw = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("release U held", u_ch.level, 1'b1);
            check("release no sp",  u_ch.sp,    1'b0);
        end
        step();
        check("release U fall", u_ch.level, 1'b0);
        check("release no sp",  u_ch.sp,    1'b0);
        step();
        step();

        // 3. bounce 1,1,0,0,1,1,0,0 then settle high
        for (int i = 0; i < 8; i++) begin
            u_ch.raw = ((i % 4) < 2) ? 1'b1 : 1'b0;
            step();
            check("bounce U", u_ch.level, 1'b0);
            check("bounce sp", u_ch.sp,   1'b0);
        end
        u_ch.raw = 1'b1;
        expect_u_rise("settle");
        sp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (u_ch.sp) sp_cnt++;
        end
        check("settle single sp", (sp_cnt == 0), 1'b1);
        u_ch.raw = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("settle released U", u_ch.level, 1'b0);

        // 4. Z held, 2-cycle release glitch must not drop the level
        z_ch.raw = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("Z rise",  z_ch.level, 1'b1);
        check("Z sp",    z_ch.sp,    1'b1);
        step();
        step();
        z_ch.raw = 1'b0;
        step();
        step();
        z_ch.raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("glitch Z held", z_ch.level, 1'b1);
            check("glitch no sp",  z_ch.sp,    1'b0);
        end
        z_ch.raw = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("Z released", z_ch.level, 1'b0);

        // 5. simultaneous press
        u_ch.raw = 1'b1;
        z_ch.raw = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("simul U low", u_ch.level, 1'b0);
            check("simul Z low", z_ch.level, 1'b0);
        end
        step();
        check("simul U",    u_ch.level, 1'b1);
        check("simul Z",    z_ch.level, 1'b1);
        check("simul U_sp", u_ch.sp,    1'b1);
        check("simul Z_sp", z_ch.sp,    1'b1);
        step();
        check("simul U_sp 1clk", u_ch.sp, 1'b0);
        check("simul Z_sp 1clk", z_ch.sp, 1'b0);
        u_ch.raw = 1'b0;
        z_ch.raw = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check_all_zero("simul released");

        // 6. reset mid-qualification (DEB_PRESS, cnt=2)
        u_ch.raw = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("midq busy", u_ch.busy, 1'b1);
        #20 reset = 1'b0;
        #1;
        check_all_zero("midq reset");
        step();
        reset = 1'b1;
        expect_u_rise("requal");
        sp_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (u_ch.sp) sp_cnt++;
        end
        check("requal single sp", (sp_cnt == 0), 1'b1);

        // reset while HELD drops the level at once; held button re-qualifies
        #20 reset = 1'b0;
        #1;
        check_all_zero("held reset");
        step();
        reset = 1'b1;
        expect_u_rise("held requal");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
